// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt sequencer: FSM state encoding,
// cause-index width, the trap register number and a one-hot helper.
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        SERVICE  = 2'd2,
        COOLDOWN = 2'd3
    } irq_state_e;

    localparam int         CAUSE_W = 3;
    localparam logic [4:0] K0_REG  = 5'd26;

    // One-hot decode of a cause index, wide enough for the largest source count
    function automatic logic [7:0] cause_onehot(input logic [CAUSE_W-1:0] cause);
        cause_onehot = 8'd1 << cause;
    endfunction

endpackage

// File: rtl/irq_picker.sv
// Combinational winner select among the active interrupt sources.
// Default build: fixed priority, lowest index wins.
// With IRQ_ROUND_ROBIN_EN defined: first active index at or after i_ptr,
// wrapping modulo NUM_SRC.
module irq_picker
    import irq_pkg::*;
#(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0] i_active,
`ifdef IRQ_ROUND_ROBIN_EN
    input  logic [CAUSE_W-1:0] i_ptr,
`endif
    output logic               o_valid,
    output logic [CAUSE_W-1:0] o_index
);

`ifdef IRQ_ROUND_ROBIN_EN
    // Scan from the pointer upward with wrap; the first hit wins
    always_comb begin
        int   w_j;
        logic w_found;
        o_valid = |i_active;
        o_index = {CAUSE_W{1'b0}};
        w_found = 1'b0;
        w_j     = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            w_j = int'(i_ptr) + k;
            if (w_j >= NUM_SRC) begin
                w_j = w_j - NUM_SRC;
            end else begin
                w_j = w_j;
            end
            if (i_active[w_j] && !w_found) begin
                o_index = CAUSE_W'(w_j);
                w_found = 1'b1;
            end else begin
                w_found = w_found;
            end
        end
    end
`else
    // Scan from the top down so the lowest active index is the last write
    always_comb begin
        o_valid = |i_active;
        o_index = {CAUSE_W{1'b0}};
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (i_active[i]) begin
                o_index = CAUSE_W'(i);
            end else begin
                o_index = o_index;
            end
        end
    end
`endif

endmodule

// File: rtl/irq_sequencer.sv
// Interrupt sequencer for the 5-stage pipeline. Arbitrates masked requests,
// waits for an ID-stage instruction that is safe to replace (valid, not
// stalled, not a branch, not in a delay slot, not kernel code, no exception),
// pulses Interrupt for that one cycle, tracks service until ERET and then
// holds off further injection for HOLDOFF cycles so user code progresses.
// Optional macro: IRQ_ROUND_ROBIN_EN selects round-robin arbitration.
module irq_sequencer
    import irq_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int HOLDOFF = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_req,
    input  logic [NUM_SRC-1:0] irq_mask,
    input  logic               id_valid,
    input  logic               id_stall,
    input  logic               id_branch,
    input  logic               id_kernel,
    input  logic               id_exception,
    input  logic               eret,
    output logic               Interrupt,
    output logic [NUM_SRC-1:0] irq_ack,
    output logic [CAUSE_W-1:0] irq_cause,
    output logic               in_service
);

    localparam logic [3:0] HOLD_INIT = 4'(HOLDOFF);

    irq_state_e           r_state;
    logic [CAUSE_W-1:0]   r_cause;
    logic [NUM_SRC-1:0]   r_ack;
    logic [3:0]           r_cnt;
    logic                 r_delay_slot;

    logic [NUM_SRC-1:0]   w_active;
    logic [NUM_SRC-1:0]   w_cause_oh;
    logic                 w_cause_active;
    logic                 w_safe;
    logic                 w_inject;
    logic                 w_eret_take;
    logic                 w_win_valid;
    logic [CAUSE_W-1:0]   w_win_index;

`ifdef IRQ_ROUND_ROBIN_EN
    logic [CAUSE_W-1:0]   r_ptr;
`endif

    assign w_active       = irq_req & irq_mask;
    assign w_cause_oh     = NUM_SRC'(cause_onehot(r_cause));
    assign w_cause_active = |(w_active & w_cause_oh);
    assign w_safe         = id_valid && !id_stall && !id_branch && !r_delay_slot
                            && !id_kernel && !id_exception;
    // Injection is Mealy: it must land on the very cycle the slot is safe
    assign w_inject       = (r_state == ARMED) && w_cause_active && w_safe;
    assign w_eret_take    = eret && id_valid && !id_stall;

    irq_picker #(
        .NUM_SRC (NUM_SRC)
    ) u_picker (
        .i_active (w_active),
`ifdef IRQ_ROUND_ROBIN_EN
        .i_ptr    (r_ptr),
`endif
        .o_valid  (w_win_valid),
        .o_index  (w_win_index)
    );

    // Remember whether the last instruction to leave ID was a branch/jump,
    // so its delay-slot instruction is never chosen for replacement
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_delay_slot <= 1'b0;
        end else if (id_valid && !id_stall) begin
            r_delay_slot <= id_branch;
        end else begin
            r_delay_slot <= r_delay_slot;
        end
    end

    // Sequencer FSM: arbitrate, arm, inject, serve until ERET, cool down.
    // COOLDOWN lasts HOLDOFF cycles; a HOLDOFF of 1 gives a single cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cause <= {CAUSE_W{1'b0}};
            r_ack   <= {NUM_SRC{1'b0}};
            r_cnt   <= 4'd0;
`ifdef IRQ_ROUND_ROBIN_EN
            r_ptr   <= {CAUSE_W{1'b0}};
`endif
        end else begin
            r_ack <= {NUM_SRC{1'b0}};
            case (r_state)
                IDLE: begin
                    if (w_win_valid) begin
                        r_cause <= w_win_index;
                        r_state <= ARMED;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                ARMED: begin
                    if (!w_cause_active) begin
                        // Source withdrew or was masked: spurious, no ack
                        r_state <= IDLE;
                    end else if (w_safe) begin
                        r_state <= SERVICE;
                        r_ack   <= w_cause_oh;
`ifdef IRQ_ROUND_ROBIN_EN
                        if (r_cause == CAUSE_W'(NUM_SRC - 1)) begin
                            r_ptr <= {CAUSE_W{1'b0}};
                        end else begin
                            r_ptr <= r_cause + CAUSE_W'(1);
                        end
`endif
                    end else begin
                        r_state <= ARMED;
                    end
                end
                SERVICE: begin
                    if (w_eret_take) begin
                        r_state <= COOLDOWN;
                        r_cnt   <= HOLD_INIT;
                    end else begin
                        r_state <= SERVICE;
                    end
                end
                COOLDOWN: begin
                    if (r_cnt <= 4'd1) begin
                        r_cnt   <= 4'd0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt   <= r_cnt - 4'd1;
                        r_state <= COOLDOWN;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign Interrupt  = w_inject;
    assign irq_ack    = r_ack;
    assign irq_cause  = r_cause;
    assign in_service = (r_state == SERVICE);

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed, table-driven bench for irq_sequencer (NUM_SRC=4, HOLDOFF=2).
// Each table row is one clock cycle: inputs are applied just after the
// rising edge and the outputs are compared on the falling edge.
module tb_irq_sequencer;

    localparam int NUM_SRC = 4;

    // flag bits: {valid, stall, branch, kernel, exception, eret}
    localparam logic [5:0] F0 = 6'b000000;
    localparam logic [5:0] FV = 6'b100000;
    localparam logic [5:0] FS = 6'b010000;
    localparam logic [5:0] FB = 6'b001000;
    localparam logic [5:0] FK = 6'b000100;
    localparam logic [5:0] FX = 6'b000010;
    localparam logic [5:0] FE = 6'b000001;

`ifdef IRQ_ROUND_ROBIN_EN
    localparam logic [2:0] C_NEXT = 3'd3;
`else
    localparam logic [2:0] C_NEXT = 3'd1;
`endif

    typedef struct {
        logic [3:0] req;
        logic [3:0] mask;
        logic [5:0] flags;
        logic       exp_int;
        logic [3:0] exp_ack;
        logic [2:0] exp_cause;
        logic       exp_ins;
    } vec_t;

    logic         clk;
    logic         reset;
    logic [3:0]   irq_req;
    logic [3:0]   irq_mask;
    logic         id_valid, id_stall, id_branch, id_kernel, id_exception, eret;
    logic         Interrupt;
    logic [3:0]   irq_ack;
    logic [2:0]   irq_cause;
    logic         in_service;

    int n_cmp;
    int n_err;
    vec_t vecs[$];

    irq_sequencer #(
        .NUM_SRC (NUM_SRC),
        .HOLDOFF (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .irq_req      (irq_req),
        .irq_mask     (irq_mask),
        .id_valid     (id_valid),
        .id_stall     (id_stall),
        .id_branch    (id_branch),
        .id_kernel    (id_kernel),
        .id_exception (id_exception),
        .eret         (eret),
        .Interrupt    (Interrupt),
        .irq_ack      (irq_ack),
        .irq_cause    (irq_cause),
        .in_service   (in_service)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] req, input logic [3:0] mask, input logic [5:0] f);
        irq_req      = req;
        irq_mask     = mask;
        id_valid     = f[5];
        id_stall     = f[4];
        id_branch    = f[3];
        id_kernel    = f[2];
        id_exception = f[1];
        eret         = f[0];
    endtask

    function automatic void add(input logic [3:0] req, input logic [3:0] mask,
                                input logic [5:0] f, input logic ei,
                                input logic [3:0] ea, input logic [2:0] ec,
                                input logic es);
        vec_t v;
        v.req = req; v.mask = mask; v.flags = f;
        v.exp_int = ei; v.exp_ack = ea; v.exp_cause = ec; v.exp_ins = es;
        vecs.push_back(v);
    endfunction

    task automatic chk_all(input string tag, input logic ei, input logic [3:0] ea,
                           input logic [2:0] ec, input logic es);
        chk({tag, " Interrupt"},  {7'd0, Interrupt},  {7'd0, ei});
        chk({tag, " irq_ack"},    {4'd0, irq_ack},    {4'd0, ea});
        chk({tag, " irq_cause"},  {5'd0, irq_cause},  {5'd0, ec});
        chk({tag, " in_service"}, {7'd0, in_service}, {7'd0, es});
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;

        // ---- A: single source 2, inject, service, ERET, holdoff, re-inject
        //   req    mask   flags    int   ack      cause ins
        add(4'h4, 4'hF, FV,      1'b0, 4'h0, 3'd0, 1'b0); // IDLE, arms
        add(4'h4, 4'hF, FV,      1'b1, 4'h0, 3'd2, 1'b0); // ARMED, safe
        add(4'h4, 4'hF, FV,      1'b0, 4'h4, 3'd2, 1'b1); // SERVICE, ack
        add(4'h4, 4'hF, FV,      1'b0, 4'h0, 3'd2, 1'b1);
        add(4'h4, 4'hF, FV|FE,   1'b0, 4'h0, 3'd2, 1'b1); // ERET taken
        add(4'h4, 4'hF, FV,      1'b0, 4'h0, 3'd2, 1'b0); // holdoff 1
        add(4'h4, 4'hF, FV,      1'b0, 4'h0, 3'd2, 1'b0); // holdoff 2
        add(4'h4, 4'hF, FV,      1'b0, 4'h0, 3'd2, 1'b0); // IDLE re-arb
        add(4'h4, 4'hF, FV,      1'b1, 4'h0, 3'd2, 1'b0); // injects again
        add(4'h4, 4'hF, FV,      1'b0, 4'h4, 3'd2, 1'b1);
        add(4'h4, 4'hF, FV|FE,   1'b0, 4'h0, 3'd2, 1'b1);
        add(4'h0, 4'hF, FV,      1'b0, 4'h0, 3'd2, 1'b0);
        add(4'h0, 4'hF, FV,      1'b0, 4'h0, 3'd2, 1'b0);
        add(4'h0, 4'hF, FV,      1'b0, 4'h0, 3'd2, 1'b0); // IDLE, quiet
        // ---- B: branch then delay slot must not be replaced
        add(4'h1, 4'hF, FV,      1'b0, 4'h0, 3'd2, 1'b0); // arms source 0
        add(4'h1, 4'hF, FV|FB,   1'b0, 4'h0, 3'd0, 1'b0); // branch
        add(4'h1, 4'hF, FV,      1'b0, 4'h0, 3'd0, 1'b0); // delay slot
        add(4'h1, 4'hF, FV,      1'b1, 4'h0, 3'd0, 1'b0); // safe
        add(4'h1, 4'hF, FV,      1'b0, 4'h1, 3'd0, 1'b1);
        add(4'h1, 4'hF, FV|FS|FE,1'b0, 4'h0, 3'd0, 1'b1); // stalled ERET ignored
        add(4'h1, 4'hF, FV|FE,   1'b0, 4'h0, 3'd0, 1'b1); // ERET taken
        add(4'h0, 4'hF, FV,      1'b0, 4'h0, 3'd0, 1'b0);
        add(4'h0, 4'hF, FV,      1'b0, 4'h0, 3'd0, 1'b0);
        add(4'h0, 4'hF, FV,      1'b0, 4'h0, 3'd0, 1'b0);
        // ---- C: priority, unsafe slots, mask race, spurious drop
        add(4'hA, 4'hF, F0,      1'b0, 4'h0, 3'd0, 1'b0); // arms source 1
        add(4'hA, 4'hF, F0,      1'b0, 4'h0, 3'd1, 1'b0); // bubble
        add(4'hA, 4'hF, FV|FK,   1'b0, 4'h0, 3'd1, 1'b0); // kernel code
        add(4'hA, 4'hF, FV|FX,   1'b0, 4'h0, 3'd1, 1'b0); // exception wins
        add(4'hA, 4'hF, FV|FS,   1'b0, 4'h0, 3'd1, 1'b0); // stall
        add(4'hA, 4'hD, FV,      1'b0, 4'h0, 3'd1, 1'b0); // mask clears winner
        add(4'hA, 4'hF, FV,      1'b0, 4'h0, 3'd1, 1'b0); // back in IDLE
        add(4'hA, 4'hF, FV,      1'b1, 4'h0, 3'd1, 1'b0); // injects
        add(4'hA, 4'hF, FV|FE,   1'b0, 4'h2, 3'd1, 1'b1);
        add(4'hA, 4'hF, FV,      1'b0, 4'h0, 3'd1, 1'b0);
        add(4'hA, 4'hF, FV,      1'b0, 4'h0, 3'd1, 1'b0);
        add(4'hA, 4'hF, FV,      1'b0, 4'h0, 3'd1, 1'b0); // IDLE re-arb
        add(4'h0, 4'hF, FV,      1'b0, 4'h0, C_NEXT, 1'b0); // dropped while safe
        add(4'h0, 4'hF, FV|FE,   1'b0, 4'h0, C_NEXT, 1'b0); // ERET in IDLE
        add(4'h0, 4'hF, FV,      1'b0, 4'h0, C_NEXT, 1'b0);

        // ---- reset state
        reset = 1'b0;
        drive(4'h0, 4'h0, F0);
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 1'b0, 4'h0, 3'd0, 1'b0);
        reset = 1'b1;

        // ---- table
        for (int r = 0; r < vecs.size(); r++) begin
            drive(vecs[r].req, vecs[r].mask, vecs[r].flags);
            @(negedge clk);
            chk_all($sformatf("row%0d", r), vecs[r].exp_int, vecs[r].exp_ack,
                    vecs[r].exp_cause, vecs[r].exp_ins);
            @(posedge clk);
            #1;
        end

        // ---- D: reset asserted mid-SERVICE
        drive(4'h4, 4'hF, FV);                  // IDLE, arms
        @(posedge clk); #1;
        chk("D armed Interrupt", {7'd0, Interrupt}, 8'd1);
        @(posedge clk); #1;
        chk("D service ack", {4'd0, irq_ack}, 8'h04);
        chk("D service in_service", {7'd0, in_service}, 8'd1);
        reset = 1'b0;
        #1;
        chk_all("D in reset", 1'b0, 4'h0, 3'd0, 1'b0);
        @(negedge clk);
        drive(4'h0, 4'hF, FV);
        reset = 1'b1;
        @(posedge clk); #1;
        chk_all("D after release", 1'b0, 4'h0, 3'd0, 1'b0);
        drive(4'h1, 4'hF, FV);                  // IDLE sees source 0
        @(posedge clk); #1;
        chk("D rearm Interrupt", {7'd0, Interrupt}, 8'd1);
        chk("D rearm cause", {5'd0, irq_cause}, 8'd0);
        @(posedge clk); #1;
        chk("D rearm ack", {4'd0, irq_ack}, 8'h01);
        chk("D rearm in_service", {7'd0, in_service}, 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/irq_sequencer.md
Name: irq_sequencer

Overview:
Interrupt controller for the 5-stage pipeline. It arbitrates external interrupt requests and chooses a safe ID-stage instruction to replace. It then drives the single-bit Interrupt input of the ID decode stage, which redirects the write to $26 and traps. It tracks kernel service until ERET and enforces a post-return holdoff, so user code always makes forward progress.

Parameters:
NUM_SRC, 4, number of interrupt sources (1..8).
HOLDOFF, 2, cycles after ERET before the next injection is allowed (1..15).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset (0 = reset).
irq_req  in  NUM_SRC  level-sensitive requests from peripherals.
irq_mask  in  NUM_SRC  per-source enable, 1 = enabled.
id_valid  in  1  ID holds a real instruction, not a bubble or flush.
id_stall  in  1  hazard unit is stalling ID this cycle.
id_branch  in  1  ID instruction is a branch or jump (Branch or Jump != 0).
id_kernel  in  1  PC[31] of the ID instruction.
id_exception  in  1  ID decode raised an exception this cycle.
eret  in  1  ID instruction is ERET and leaves ID this cycle.
Interrupt  out  1  to ID control; converts the current ID instruction into an interrupt trap.
irq_ack  out  NUM_SRC  one-hot, 1-cycle acknowledge to the serviced source.
irq_cause  out  3  index of the source being or last serviced.
in_service  out  1  high from injection until ERET.

Behaviour:
- Reset (asynchronous, reset=0): state=IDLE; Interrupt=0; irq_ack=0; irq_cause=0; in_service=0; holdoff counter=0; delay-slot flag=0; round-robin pointer=0.
- active = irq_req & irq_mask.
- delay-slot flag: a register set to id_branch when id_valid && !id_stall; otherwise it holds.
- safe = id_valid && !id_stall && !id_branch && !delay_slot && !id_kernel && !id_exception.
- States:
  - IDLE:
    - If |active, latch the winner index into irq_cause and go to ARMED.
    - Winner is the lowest index, unless the optional feature below is compiled in.
  - ARMED:
    - If the latched source drops from active, return to IDLE; the request is treated as spurious and is not acked.
    - Otherwise, if safe, Interrupt=1 combinationally in the same cycle and go to SERVICE.
    - Else wait; there is no timeout.
  - SERVICE:
    - On entry edge, irq_ack[irq_cause]=1 for exactly one cycle; in_service=1.
    - Interrupt=0 throughout.
    - eret && id_valid && !id_stall -> COOLDOWN, counter loaded with HOLDOFF.
  - COOLDOWN:
    - Counter decrements each cycle; in_service=0.
    - At 0 go to IDLE. Pending requests are re-arbitrated there, not carried over.
- Interrupt is Mealy: high only in ARMED && safe, and high at most once per service.
- Simultaneous events:
  - id_exception with a pending irq: the exception wins; stay ARMED.
  - irq_mask clears the winner in the same cycle as safe: no injection; go to IDLE.
  - eret in any state other than SERVICE is ignored.
- Reset mid-SERVICE or mid-ARMED: immediate return to IDLE; no ack is issued.

Optional Feature:
IRQ_ROUND_ROBIN_EN
- Defined: winner is the first active index at or after the round-robin pointer, wrapping modulo NUM_SRC. The pointer becomes winner+1 (mod NUM_SRC) when SERVICE is entered.
- Undefined: fixed priority, lowest index wins; the pointer register is absent.

Decomposition:
- Package irq_pkg holds:
  - the state encoding (IDLE=2'd0, ARMED=2'd1, SERVICE=2'd2, COOLDOWN=2'd3);
  - CAUSE_W=3;
  - the trap register constant K0_REG=5'd26.
- One sub-module, irq_picker: combinational winner select from active plus pointer, producing valid and index. It contains the round-robin logic under the macro.

Test Plan:
- irq_req=4'b0100, mask=4'hF, id_valid=1, no branch/stall/kernel -> Interrupt=1 one cycle after arming; irq_ack=4'b0100 next cycle; irq_cause=2; in_service=1.
- Armed, then id_branch=1 for one cycle followed by a safe slot -> no Interrupt on the branch cycle or the delay-slot cycle; Interrupt on the cycle after the delay slot.
- SERVICE, then eret with HOLDOFF=2 and irq_req still high -> in_service falls; no Interrupt for 2 cycles; then re-arms and injects again.
- irq_req=4'b1010 fixed priority -> cause=1. With IRQ_ROUND_ROBIN_EN after servicing 1 -> next cause=3.
- Armed with irq_req dropped before a safe slot -> return to IDLE; irq_ack stays 0.
- Assert reset=0 in SERVICE -> Interrupt, in_service and irq_ack are 0 immediately; state is IDLE after release.
